// File: rtl/vend_credit_fsm.sv
// Coin-accumulation and vend controller: edge-detects coins/cancel, tracks credit in
// nickel units, then sequences the dispense pulse and nickel-by-nickel change return.
//
// state  | meaning
// IDLE   | no credit held
// ACCUM  | 0 < credit < PRICE, waiting for more coins or cancel
// VEND   | dispense held high while the vend timer counts down
// CHANGE | returning change_cnt nickels, one pulse every other cycle
module vend_credit_fsm #(
    parameter int PRICE       = 8,
    parameter int VEND_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_n,
    input  logic       coin_d,
    input  logic       coin_q,
    input  logic       cancel,
    output logic [3:0] credit,
    output logic       dispense,
    output logic       change_nickel,
    output logic       coin_reject,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

    localparam logic [3:0] PRICE_C = 4'(PRICE);
    localparam logic [4:0] PRICE_W = 5'(PRICE);
    localparam logic [3:0] VEND_C  = 4'(VEND_CYCLES);

    state_t     state, state_nxt;
    logic       prev_n, prev_d, prev_q, prev_c;
    logic [2:0] change_cnt, change_cnt_nxt;
    logic [3:0] timer, timer_nxt;
    logic [3:0] credit_nxt;
    logic       dispense_nxt, change_nickel_nxt, coin_reject_nxt, busy_nxt;

    logic       ev_n, ev_d, ev_q, ev_c;
    logic [1:0] n_ev;
    logic [2:0] coin_val;
    logic [4:0] sum;

    assign ev_n     = coin_n & ~prev_n;
    assign ev_d     = coin_d & ~prev_d;
    assign ev_q     = coin_q & ~prev_q;
    assign ev_c     = cancel & ~prev_c;
    assign n_ev     = 2'(ev_n) + 2'(ev_d) + 2'(ev_q);
    assign coin_val = ev_q ? 3'd5 : (ev_d ? 3'd2 : (ev_n ? 3'd1 : 3'd0));
    assign sum      = {1'b0, credit} + {2'b00, coin_val};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            credit        <= '0;
            change_cnt    <= '0;
            timer         <= '0;
            dispense      <= 1'b0;
            change_nickel <= 1'b0;
            coin_reject   <= 1'b0;
            busy          <= 1'b0;
            prev_n        <= 1'b0;
            prev_d        <= 1'b0;
            prev_q        <= 1'b0;
            prev_c        <= 1'b0;
        end else begin
            state         <= state_nxt;
            credit        <= credit_nxt;
            change_cnt    <= change_cnt_nxt;
            timer         <= timer_nxt;
            dispense      <= dispense_nxt;
            change_nickel <= change_nickel_nxt;
            coin_reject   <= coin_reject_nxt;
            busy          <= busy_nxt;
            prev_n        <= coin_n;
            prev_d        <= coin_d;
            prev_q        <= coin_q;
            prev_c        <= cancel;
        end
    end

    always_comb begin
        state_nxt         = state;
        credit_nxt        = credit;
        change_cnt_nxt    = change_cnt;
        timer_nxt         = timer;
        dispense_nxt      = dispense;
        change_nickel_nxt = 1'b0;
        coin_reject_nxt   = 1'b0;
        busy_nxt          = busy;

        case (state)
            IDLE, ACCUM: begin
                dispense_nxt = 1'b0;
                busy_nxt     = 1'b0;
                if (ev_c) begin
                    coin_reject_nxt = (n_ev != 2'd0);
                    if (credit != 4'd0) begin
                        // credit < PRICE <= 8 here, so it fits the 3-bit change count
                        change_cnt_nxt = credit[2:0];
                        credit_nxt     = '0;
                        busy_nxt       = 1'b1;
                        state_nxt      = CHANGE;
                    end
                end else if (n_ev > 2'd1) begin
                    coin_reject_nxt = 1'b1;
                end else if (n_ev == 2'd1) begin
                    if (sum < PRICE_W) begin
                        credit_nxt = sum[3:0];
                        state_nxt  = ACCUM;
                    end else begin
                        credit_nxt     = PRICE_C;
                        change_cnt_nxt = 3'(sum - PRICE_W);
                        timer_nxt      = VEND_C;
                        dispense_nxt   = 1'b1;
                        busy_nxt       = 1'b1;
                        state_nxt      = VEND;
                    end
                end
            end

            VEND: begin
                coin_reject_nxt = (n_ev != 2'd0);
                if (timer <= 4'd1) begin
                    timer_nxt    = '0;
                    credit_nxt   = '0;
                    dispense_nxt = 1'b0;
                    if (change_cnt != 3'd0) begin
                        state_nxt = CHANGE;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer - 4'd1;
                end
            end

            CHANGE: begin
                coin_reject_nxt = (n_ev != 2'd0);
                credit_nxt      = '0;
                // change_nickel doubles as the high/low phase of the pulse train
                if (!change_nickel) begin
                    if (change_cnt != 3'd0) begin
                        change_nickel_nxt = 1'b1;
                        change_cnt_nxt    = change_cnt - 3'd1;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule
